shadow_register_restorer: RTL and testbench

Restores a shadow-register frame from the memory stack back into the integer register file and the mepc/mcause CSRs when a trap handler returns. It is the load-side counterpart of the shadow save path. It accepts one restore request at a time, streams pipelined word loads to the data cache, and writes each returned word into the register file as it arrives. It sits between the commit/CSR logic that detects the trap return, the LSU data-cache port, and a dedicated register-file write port.

---
 rtl/shadow_register_restorer.sv | 218 +++++++++++++++++++++
 tb/tb_shadow_register_restorer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_register_restorer.sv
// shadow_register_restorer
//   Reloads a saved shadow-register frame from the stack into the integer
//   register file and the mepc/mcause CSRs on trap return. Word loads are
//   pipelined to the data cache (up to MAX_OUTSTANDING in flight), and each
//   returned word goes straight to a dedicated register-file write port.
//   Frame slots (word k at sp + k*WB): 0 = mepc, 1 and 3..31 = x[k],
//   2 = unused, 32 = mcause. x2 is rebuilt as sp + 33*WB.
// Ports
//   clk_i, rst_ni               clock, synchronous active-low reset
//   restore_req_i/restore_sp_i  restore request and frame base address
//   restore_ready_o             idle, request can be accepted
//   mem_req_o/mem_addr_o/mem_gnt_i                 load request handshake
//   mem_rvalid_i/mem_rdata_i/mem_err_i             in-order load responses
//   rf_we_o/rf_waddr_o/rf_wdata_o                  register-file write port
//   csr_valid_o/mepc_o/mcause_o                    restored CSR values
//   done_o/error_o              completion / abort pulses
module shadow_register_restorer #(
  parameter int XLEN            = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  restore_req_i,
  input  logic [ADDR_WIDTH-1:0] restore_sp_i,
  output logic                  restore_ready_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  csr_valid_o,
  output logic [XLEN-1:0]       mepc_o,
  output logic [XLEN-1:0]       mcause_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int WB       = XLEN / 8;
  localparam int WB_SHIFT = $clog2(WB);
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(WB - 1);
  localparam logic [ADDR_WIDTH-1:0] FRAME_BYTES = ADDR_WIDTH'(33 * WB);
  localparam logic [CNT_W-1:0]      MAX_OUT     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [5:0]            SLOT_MEPC   = 6'd0;
  localparam logic [5:0]            SLOT_MCAUSE = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_FINISH = 3'd3,
    S_ABORT  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sp_q, sp_d;
  logic [5:0]              issue_idx_q, issue_idx_d;
  logic [5:0]              resp_idx_q, resp_idx_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic                    err_q, err_d;
  logic [XLEN-1:0]         mepc_q, mepc_d;
  logic [XLEN-1:0]         mcause_q, mcause_d;

  logic                    resp_active_s;
  logic                    resp_err_s;
  logic                    resp_ok_s;
  logic                    issue_s;
  logic                    slot_is_gpr_s;
  logic [ADDR_WIDTH-1:0]   sp_end_s;

  // Slot sequence skips index 2 (x2 is regenerated, never loaded).
  function automatic logic [5:0] next_slot(input logic [5:0] idx);
    if (idx == 6'd1) begin
      return 6'd3;
    end else begin
      return idx + 6'd1;
    end
  endfunction

  // A response is only meaningful while loads are known to be in flight;
  // stray beats (e.g. after a mid-restore reset) fall through silently.
  assign resp_active_s = mem_rvalid_i && (outstanding_q != '0) &&
                         ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign resp_err_s    = resp_active_s && mem_err_i;
  assign resp_ok_s     = resp_active_s && !mem_err_i && !err_q;
  assign slot_is_gpr_s = (resp_idx_q != SLOT_MEPC) && (resp_idx_q != SLOT_MCAUSE);
  assign sp_end_s      = sp_q + FRAME_BYTES;

  // An error beat withdraws the request in the same cycle so nothing new issues.
  assign mem_req_o  = (state_q == S_ISSUE) && (outstanding_q < MAX_OUT) && !resp_err_s;
  assign issue_s    = mem_req_o && mem_gnt_i;
  assign mem_addr_o = (state_q == S_ISSUE) ?
                      (sp_q + (ADDR_WIDTH'(issue_idx_q) << WB_SHIFT)) : '0;

  assign restore_ready_o = (state_q == S_IDLE);
  assign rf_we_o         = (resp_ok_s && slot_is_gpr_s) || (state_q == S_FINISH);
  assign rf_waddr_o      = (state_q == S_FINISH) ? 5'd2 :
                           (rf_we_o ? resp_idx_q[4:0] : 5'd0);
  assign rf_wdata_o      = (state_q == S_FINISH) ? XLEN'(sp_end_s) :
                           (rf_we_o ? mem_rdata_i : '0);
  assign csr_valid_o     = (state_q == S_FINISH);
  assign done_o          = (state_q == S_FINISH);
  assign error_o         = (state_q == S_ABORT);
  assign mepc_o          = mepc_q;
  assign mcause_o        = mcause_q;

  // Next-state computation for the sequencer, counters and CSR latches
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    err_d       = err_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;

    // Simultaneous grant and response cancel out.
    case ({issue_s, resp_active_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (issue_s) begin
      issue_idx_d = next_slot(issue_idx_q);
    end else begin
      issue_idx_d = issue_idx_q;
    end

    if (resp_active_s) begin
      resp_idx_d = next_slot(resp_idx_q);
    end else begin
      resp_idx_d = resp_idx_q;
    end

    if (resp_ok_s && (resp_idx_q == SLOT_MEPC)) begin
      mepc_d = mem_rdata_i;
    end else if (resp_ok_s && (resp_idx_q == SLOT_MCAUSE)) begin
      mcause_d = mem_rdata_i;
    end else begin
      mepc_d = mepc_q;
    end

    if (resp_err_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        if (restore_req_i) begin
          sp_d          = restore_sp_i;
          issue_idx_d   = 6'd0;
          resp_idx_d    = 6'd0;
          outstanding_d = '0;
          err_d         = 1'b0;
          if ((restore_sp_i & ALIGN_MASK) != '0) begin
            state_d = S_ABORT;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (resp_err_s) begin
          state_d = S_DRAIN;
        end else if (issue_s && (issue_idx_q == SLOT_MCAUSE)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Looking at the post-response count lets the last beat and the
        // exit decision share a cycle.
        if (outstanding_d == '0) begin
          state_d = err_d ? S_ABORT : S_FINISH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      sp_q          <= '0;
      issue_idx_q   <= 6'd0;
      resp_idx_q    <= 6'd0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      mepc_q        <= '0;
      mcause_q      <= '0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      issue_idx_q   <= issue_idx_d;
      resp_idx_q    <= resp_idx_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
    end
  end

endmodule

// File: tb/tb_shadow_register_restorer.sv
// Directed testbench for shadow_register_restorer: a small in-order memory
// model with configurable latency, stall and error injection, plus a
// register-file shadow built from observed write-port activity.
module tb_shadow_register_restorer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        restore_req_i;
  logic [63:0] restore_sp_i;
  logic        restore_ready_o;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_err_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic        csr_valid_o;
  logic [63:0] mepc_o;
  logic [63:0] mcause_o;
  logic        done_o;
  logic        error_o;

  always #5 clk = ~clk;

  shadow_register_restorer #(
    .XLEN(64), .ADDR_WIDTH(64), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .restore_req_i(restore_req_i), .restore_sp_i(restore_sp_i),
    .restore_ready_o(restore_ready_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .csr_valid_o(csr_valid_o), .mepc_o(mepc_o), .mcause_o(mcause_o),
    .done_o(done_o), .error_o(error_o)
  );

  typedef struct {
    logic [63:0] a;
    int          c;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] rf_m [32];
  bit          wr_m [32];

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus controls
  bit          rst_drv, req_drv, err_en;
  logic [63:0] base_sp, stall_addr, err_addr;
  int          lat, stall_left, rst_slot;

  // observations
  int          cyc = 0;
  bit          accepted, erred, saw_slot;
  int          acc_cyc, ready_cyc, first_req_cyc, done_cyc, err_cyc, last_resp_cyc;
  int          grants, grants_after_err, resp_after_err, stall_cycles, max_infl;
  int          wr_cnt, we_idle, rv_idle, csr_cnt, done_cnt, err_cnt;
  logic [63:0] addr_idx1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] off;
    off = a - base_sp;
    return 64'h1000 + (off >> 3);
  endfunction

  function automatic int regs_bad();
    int bad;
    bad = 0;
    for (int k = 1; k < 32; k++) begin
      if (k != 2) begin
        if (!wr_m[k] || (rf_m[k] !== 64'h1000 + 64'(k))) bad++;
      end
    end
    return bad;
  endfunction

  task automatic clear_run();
    pend.delete();
    for (int k = 0; k < 32; k++) begin
      rf_m[k] = 64'd0;
      wr_m[k] = 1'b0;
    end
    accepted = 1'b0; erred = 1'b0; saw_slot = 1'b0;
    acc_cyc = -1; ready_cyc = -1; first_req_cyc = -1; done_cyc = -1;
    err_cyc = -1; last_resp_cyc = -1;
    grants = 0; grants_after_err = 0; resp_after_err = 0; stall_cycles = 0;
    max_infl = 0; wr_cnt = 0; we_idle = 0; rv_idle = 0; csr_cnt = 0;
    done_cnt = 0; err_cnt = 0; addr_idx1 = 64'hDEAD;
  endtask

  // One clock: drive inputs after the falling edge, then observe the DUT.
  task automatic step();
    pend_t p;
    pend_t q;
    @(negedge clk);
    rst_ni        = rst_drv;
    restore_req_i = req_drv;
    restore_sp_i  = base_sp;
    if ((pend.size() > 0) && (pend[0].c + lat <= cyc)) begin
      p = pend.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(p.a);
      mem_err_i    = err_en && (p.a == err_addr);
      if ((rst_slot >= 0) && (p.a == base_sp + 64'(rst_slot) * 64'd8)) saw_slot = 1'b1;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 64'd0;
      mem_err_i    = 1'b0;
    end
    #1;
    if ((stall_left > 0) && mem_req_o && (mem_addr_o == stall_addr)) begin
      mem_gnt_i = 1'b0;
      stall_left--;
      stall_cycles++;
    end else begin
      mem_gnt_i = 1'b1;
    end
    #1;
    if (restore_ready_o && restore_req_i && !accepted) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
    end
    if (accepted && (cyc > acc_cyc) && restore_ready_o && (ready_cyc < 0)) ready_cyc = cyc;
    if (mem_req_o && (first_req_cyc < 0)) first_req_cyc = cyc;
    if (mem_req_o && mem_gnt_i) begin
      if (grants == 1) addr_idx1 = mem_addr_o;
      grants++;
      if (erred) grants_after_err++;
      q.a = mem_addr_o;
      q.c = cyc;
      pend.push_back(q);
    end
    if (mem_rvalid_i) begin
      last_resp_cyc = cyc;
      if (erred) resp_after_err++;
      if (restore_ready_o) rv_idle++;
    end
    if (mem_rvalid_i && mem_err_i) erred = 1'b1;
    if (pend.size() > max_infl) max_infl = pend.size();
    if (rf_we_o) begin
      rf_m[rf_waddr_o] = rf_wdata_o;
      wr_m[rf_waddr_o] = 1'b1;
      wr_cnt++;
      if (restore_ready_o) we_idle++;
    end
    if (csr_valid_o) csr_cnt++;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (error_o) begin err_cnt++; err_cyc = cyc; end
    cyc++;
  endtask

  task automatic run_restore(input logic [63:0] sp, input int l,
                             input logic [63:0] st_addr, input int st_n,
                             input logic [63:0] e_addr, input bit e_en,
                             input int r_slot);
    clear_run();
    base_sp = sp; lat = l; stall_addr = st_addr; stall_left = st_n;
    err_addr = e_addr; err_en = e_en; rst_slot = r_slot;
    req_drv = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (accepted) req_drv = 1'b0;
      if ((rst_slot >= 0) && saw_slot) begin
        rst_drv = 1'b0;
        step();
        rst_drv = 1'b1;
        step();
        break;
      end
      if ((done_cnt > 0) || (err_cnt > 0)) break;
    end
    req_drv = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst_ni = 1'b0; restore_req_i = 1'b0; restore_sp_i = 64'd0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0; mem_err_i = 1'b0;
    rst_drv = 1'b0; req_drv = 1'b0; err_en = 1'b0; base_sp = 64'd0;
    stall_addr = 64'd0; err_addr = 64'd0; lat = 1; stall_left = 0; rst_slot = -1;
    clear_run();
    repeat (2) step();
    rst_drv = 1'b1;
    step();

    // reset state
    check_value("rst_ready",  restore_ready_o, 64'd1);
    check_value("rst_memreq", mem_req_o,       64'd0);
    check_value("rst_rfwe",   rf_we_o,         64'd0);
    check_value("rst_flags",  {csr_valid_o, done_o, error_o}, 64'd0);
    check_value("rst_mepc",   mepc_o,          64'd0);
    check_value("rst_mcause", mcause_o,        64'd0);

    // aligned restore, zero-wait grant, 1-cycle responses
    run_restore(64'h8000_0000, 1, 64'd0, 0, 64'd0, 1'b0, -1);
    check_value("al_first_req", first_req_cyc - acc_cyc, 64'd1);
    check_value("al_last_resp", last_resp_cyc - acc_cyc, 64'd33);
    check_value("al_done_t",    done_cyc - acc_cyc,      64'd34);
    check_value("al_ready_t",   ready_cyc - acc_cyc,     64'd35);
    check_value("al_counts",    {32'(done_cnt), 16'(err_cnt), 16'(csr_cnt)}, {32'd1, 16'd0, 16'd1});
    check_value("al_x1",        rf_m[1],  64'h1001);
    check_value("al_x31",       rf_m[31], 64'h101F);
    check_value("al_regs_bad",  regs_bad(), 64'd0);
    check_value("al_x2",        rf_m[2],  64'h8000_0108);
    check_value("al_wr_cnt",    wr_cnt,   64'd31);
    check_value("al_mepc",      mepc_o,   64'h1000);
    check_value("al_mcause",    mcause_o, 64'h1020);

    // back-pressure on index 7 with 2-cycle responses
    run_restore(64'h8000_0000, 2, 64'h8000_0038, 5, 64'd0, 1'b0, -1);
    check_value("bp_stall",     stall_cycles, 64'd5);
    check_value("bp_grants",    grants,       64'd32);
    check_value("bp_max_infl",  max_infl,     64'd2);
    check_value("bp_regs_bad",  regs_bad(),   64'd0);
    check_value("bp_x2",        rf_m[2],      64'h8000_0108);
    check_value("bp_done",      done_cnt,     64'd1);
    check_value("bp_csr",       {mepc_o[31:0], mcause_o[31:0]}, {32'h1000, 32'h1020});

    // error on the slot-10 response while slot 11 is still in flight
    run_restore(64'h8000_0000, 2, 64'h8000_0008, 1, 64'h8000_0050, 1'b1, -1);
    check_value("er_x9_written", wr_m[9],         64'd1);
    check_value("er_x10_skip",   wr_m[10],        64'd0);
    check_value("er_x11_skip",   wr_m[11],        64'd0);
    check_value("er_x2_skip",    wr_m[2],         64'd0);
    check_value("er_no_issue",   grants_after_err, 64'd0);
    check_value("er_consumed",   resp_after_err,  64'd1);
    check_value("er_pend_empty", pend.size(),     64'd0);
    check_value("er_pulses",     {32'(err_cnt), 16'(done_cnt), 16'(csr_cnt)}, {32'd1, 16'd0, 16'd0});
    check_value("er_ready",      restore_ready_o, 64'd1);
    err_en = 1'b0;

    // misaligned frame base
    run_restore(64'h8000_0004, 1, 64'd0, 0, 64'd0, 1'b0, -1);
    check_value("ma_err_t",    err_cyc - acc_cyc, 64'd1);
    check_value("ma_no_req",   first_req_cyc,     -64'sd1);
    check_value("ma_no_write", wr_cnt,            64'd0);
    check_value("ma_pulses",   {err_cnt, done_cnt}, {32'd1, 32'd0});

    // reset while responses are still returning
    run_restore(64'h8000_0000, 1, 64'd0, 0, 64'd0, 1'b0, 15);
    check_value("rs_ready",    restore_ready_o, 64'd1);
    check_value("rs_memreq",   mem_req_o,       64'd0);
    check_value("rs_idle_rv",  rv_idle,         64'd1);
    check_value("rs_idle_we",  we_idle,         64'd0);
    check_value("rs_mepc",     mepc_o,          64'd0);
    check_value("rs_done",     done_cnt + err_cnt, 64'd0);
    run_restore(64'h8000_0000, 1, 64'd0, 0, 64'd0, 1'b0, -1);
    check_value("rs2_done_t",  done_cyc - acc_cyc, 64'd34);
    check_value("rs2_regs",    regs_bad(),      64'd0);
    check_value("rs2_x2",      rf_m[2],         64'h8000_0108);
    check_value("rs2_csr",     {mepc_o[31:0], mcause_o[31:0]}, {32'h1000, 32'h1020});

    // address wrap at the top of the address space
    run_restore(64'hFFFF_FFFF_FFFF_FFF8, 1, 64'd0, 0, 64'd0, 1'b0, -1);
    check_value("wr_idx1_addr", addr_idx1, 64'h0);
    check_value("wr_x2",        rf_m[2],   64'h100);
    check_value("wr_regs",      regs_bad(), 64'd0);
    check_value("wr_done",      done_cnt,  64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
